param_shift_sequencer: RTL and testbench

- Parametrised universal shift/rotate register; successor to the team's 8-bit rotate/ASR register.
- Supports parallel load, plus multi-step shift operations executed one bit per enabled cycle under a start/busy/done handshake.
- Sits between switch/datapath inputs and LED/display or downstream serial logic.
- Replaces gated-clock stepping with a clock enable, so everything runs on clk.

---
 rtl/param_shift_sequencer.sv | 146 ++++++++++++++
 tb/tb_param_shift_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/param_shift_sequencer.sv
// Parametrised universal shift/rotate register with parallel load.
// A start request latches an operation and a step count, then the
// register advances one bit per enabled clock until the count runs out,
// signalling completion with a one-cycle done pulse.

module param_shift_sequencer #(
   parameter int WIDTH = 8,
   parameter int AMT_W = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             load,
   input  logic [WIDTH-1:0] load_data,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [AMT_W-1:0] amount,
   input  logic             serial_in,
   output logic [WIDTH-1:0] q,
   output logic             serial_out,
   output logic             busy,
   output logic             done
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   localparam logic [2:0] OP_ROR = 3'b001;
   localparam logic [2:0] OP_ROL = 3'b010;
   localparam logic [2:0] OP_LSR = 3'b011;
   localparam logic [2:0] OP_LSL = 3'b100;
   localparam logic [2:0] OP_ASR = 3'b101;

   state_t           state;
   state_t           state_n;
   logic [WIDTH-1:0] q_n;
   logic             so_n;
   logic             done_n;
   logic [AMT_W-1:0] cnt;
   logic [AMT_W-1:0] cnt_n;
   logic [2:0]       op_lat;
   logic [2:0]       op_n;
   logic [WIDTH-1:0] step_q;
   logic             step_so;

   // Result of a single step of the latched operation; HOLD and the
   // reserved codes leave both the register and serial_out untouched.
   always_comb begin
      step_q  = q;
      step_so = serial_out;
      case (op_lat)
         OP_ROR: begin
            step_q  = {q[0], q[WIDTH-1:1]};
            step_so = q[0];
         end
         OP_ROL: begin
            step_q  = {q[WIDTH-2:0], q[WIDTH-1]};
            step_so = q[WIDTH-1];
         end
         OP_LSR: begin
            step_q  = {serial_in, q[WIDTH-1:1]};
            step_so = q[0];
         end
         OP_LSL: begin
            step_q  = {q[WIDTH-2:0], serial_in};
            step_so = q[WIDTH-1];
         end
         OP_ASR: begin
            step_q  = {q[WIDTH-1], q[WIDTH-1:1]};
            step_so = q[0];
         end
         default: begin
            step_q  = q;
            step_so = serial_out;
         end
      endcase
   end

   // Next-state and datapath decisions: load always wins over start in
   // IDLE and aborts a run in RUN; a zero-length request completes at once.
   always_comb begin
      state_n = state;
      q_n     = q;
      so_n    = serial_out;
      cnt_n   = cnt;
      op_n    = op_lat;
      done_n  = 1'b0;
      case (state)
         IDLE: begin
            if (load) begin
               q_n = load_data;
            end else if (start) begin
               if (amount != '0) begin
                  op_n    = op;
                  cnt_n   = amount;
                  state_n = RUN;
               end else begin
                  done_n = 1'b1;
               end
            end
         end
         RUN: begin
            if (load) begin
               q_n     = load_data;
               cnt_n   = '0;
               state_n = IDLE;
            end else if (en) begin
               q_n   = step_q;
               so_n  = step_so;
               cnt_n = cnt - 1'b1;
               if (cnt == AMT_W'(1)) begin
                  done_n  = 1'b1;
                  state_n = IDLE;
               end
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         q          <= '0;
         serial_out <= 1'b0;
         cnt        <= '0;
         op_lat     <= '0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         q          <= q_n;
         serial_out <= so_n;
         cnt        <= cnt_n;
         op_lat     <= op_n;
         done       <= done_n;
      end
   end

   assign busy = (state == RUN);

endmodule

// File: tb/tb_param_shift_sequencer.sv
// Self-checking bench for param_shift_sequencer (WIDTH=8, AMT_W=4).
// A transaction-level reference model computes each step with plain
// integer arithmetic and is compared against the DUT every cycle.

module tb_param_shift_sequencer;

   localparam int W = 8;
   localparam int A = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         en = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] load_data = '0;
   logic         start = 1'b0;
   logic [2:0]   op = '0;
   logic [A-1:0] amount = '0;
   logic         serial_in = 1'b0;
   logic [W-1:0] q;
   logic         serial_out;
   logic         busy;
   logic         done;

   int tests_run = 0;
   int tests_failed = 0;

   int m_q = 0;
   int m_so = 0;
   int m_busy = 0;
   int m_done = 0;
   int m_left = 0;
   int m_op = 0;

   param_shift_sequencer #(.WIDTH(W), .AMT_W(A)) dut (
      .clk(clk), .reset(reset), .en(en), .load(load), .load_data(load_data),
      .start(start), .op(op), .amount(amount), .serial_in(serial_in),
      .q(q), .serial_out(serial_out), .busy(busy), .done(done)
   );

   // Free-running clock
   always #5 clk = ~clk;

   // One single-bit step of an operation, worked out arithmetically
   task automatic model_step(input int opc, input int sin);
      int v;
      v = m_q;
      case (opc)
         1: begin m_so = v % 2;   m_q = v / 2 + m_so * 128; end
         2: begin m_so = v / 128; m_q = (v * 2) % 256 + m_so; end
         3: begin m_so = v % 2;   m_q = v / 2 + sin * 128; end
         4: begin m_so = v / 128; m_q = (v * 2) % 256 + sin; end
         5: begin m_so = v % 2;   m_q = v / 2 + ((v >= 128) ? 128 : 0); end
         default: begin end
      endcase
   endtask

   // Advance one clock edge and update the reference model from the
   // inputs seen at that edge; outputs are then sampled 1ns later
   task automatic tick();
      @(posedge clk);
      if (reset) begin
         m_q = 0; m_so = 0; m_busy = 0; m_done = 0; m_left = 0; m_op = 0;
      end else begin
         m_done = 0;
         if (m_busy == 0) begin
            if (load) m_q = int'(load_data);
            else if (start) begin
               if (amount == 0) m_done = 1;
               else begin
                  m_busy = 1; m_left = int'(amount); m_op = int'(op);
               end
            end
         end else if (load) begin
            m_q = int'(load_data); m_busy = 0; m_left = 0;
         end else if (en) begin
            model_step(m_op, int'(serial_in));
            m_left = m_left - 1;
            if (m_left == 0) begin
               m_busy = 0; m_done = 1;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      tick();
      tick();
      tests_run++;
      if ({q, serial_out, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL reset: q=%h so=%b busy=%b done=%b, expected all zero",
                  q, serial_out, busy, done);
      end
      reset = 1'b0;
   endtask

   typedef struct {
      logic [7:0] ld;
      logic [2:0] opc;
      logic [3:0] amt;
      logic       sin;
      logic [7:0] fin;
   } vec_t;

   task automatic test_shift_ops();
      vec_t tbl[5];
      int   pulses;
      tbl[0] = '{8'h96, 3'b001, 4'd3, 1'b0, 8'hD2};
      tbl[1] = '{8'h90, 3'b101, 4'd2, 1'b0, 8'hE4};
      tbl[2] = '{8'h90, 3'b011, 4'd2, 1'b0, 8'h24};
      tbl[3] = '{8'h0F, 3'b100, 4'd4, 1'b1, 8'hFF};
      tbl[4] = '{8'hA5, 3'b010, 4'd8, 1'b0, 8'hA5};
      en = 1'b1;
      for (int t = 0; t < 5; t++) begin
         load = 1'b1; load_data = tbl[t].ld;
         tick();
         load = 1'b0; start = 1'b1; op = tbl[t].opc; amount = tbl[t].amt;
         serial_in = tbl[t].sin;
         tick();
         start = 1'b0; op = 3'b000; amount = '0; load_data = 8'h00;
         tests_run++;
         if (busy !== 1'b1 || q !== tbl[t].ld) begin
            tests_failed++;
            $display("[TB] FAIL accept[%0d]: busy=%b q=%h, expected busy=1 q=%h",
                     t, busy, q, tbl[t].ld);
         end
         pulses = 0;
         for (int i = 0; i < int'(tbl[t].amt); i++) begin
            tick();
            if (done) pulses++;
            tests_run++;
            if ({q, serial_out, busy, done} !== {m_q[7:0], m_so[0], m_busy[0], m_done[0]}) begin
               tests_failed++;
               $display("[TB] FAIL shift_ops[%0d] step %0d: q=%h so=%b busy=%b done=%b, expected q=%h so=%b busy=%b done=%b",
                        t, i, q, serial_out, busy, done, m_q[7:0], m_so[0], m_busy[0], m_done[0]);
            end
         end
         tests_run++;
         if (q !== tbl[t].fin || done !== 1'b1 || busy !== 1'b0 || pulses != 1) begin
            tests_failed++;
            $display("[TB] FAIL final[%0d]: q=%h done=%b busy=%b pulses=%0d, expected q=%h done=1 busy=0 pulses=1",
                     t, q, done, busy, pulses, tbl[t].fin);
         end
         tick();
         tests_run++;
         if (done !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL done_width[%0d]: done=%b, expected 0", t, done);
         end
      end
   endtask

   task automatic test_stall();
      logic pat[7];
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      load = 1'b1; load_data = 8'h01;
      tick();
      load = 1'b0; start = 1'b1; op = 3'b001; amount = 4'd4; en = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 7; i++) begin
         en = pat[i];
         tick();
         tests_run++;
         if ({q, serial_out, busy, done} !== {m_q[7:0], m_so[0], m_busy[0], m_done[0]}
             || busy !== (i < 6)) begin
            tests_failed++;
            $display("[TB] FAIL stall step %0d: q=%h so=%b busy=%b done=%b, expected q=%h so=%b busy=%b done=%b",
                     i, q, serial_out, busy, done, m_q[7:0], m_so[0], m_busy[0], m_done[0]);
         end
      end
      tests_run++;
      if (q !== 8'h10 || done !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL stall final: q=%h done=%b, expected q=10 done=1", q, done);
      end
      en = 1'b1;
      tick();
   endtask

   task automatic test_zero_and_priority();
      load = 1'b1; load_data = 8'h5A;
      tick();
      load = 1'b0; start = 1'b1; op = 3'b001; amount = 4'd0;
      tick();
      start = 1'b0;
      tests_run++;
      if (done !== 1'b1 || busy !== 1'b0 || q !== 8'h5A) begin
         tests_failed++;
         $display("[TB] FAIL zero_amount: done=%b busy=%b q=%h, expected done=1 busy=0 q=5a",
                  done, busy, q);
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL zero_amount after: done=%b busy=%b, expected 0 0", done, busy);
      end
      load = 1'b1; start = 1'b1; load_data = 8'h33; amount = 4'd3;
      tick();
      load = 1'b0; start = 1'b0;
      tick();
      tests_run++;
      if (q !== 8'h33 || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL load_over_start: q=%h busy=%b done=%b, expected q=33 busy=0 done=0",
                  q, busy, done);
      end
   endtask

   task automatic test_abort_reset();
      en = 1'b1;
      load = 1'b1; load_data = 8'h81;
      tick();
      load = 1'b0; start = 1'b1; op = 3'b001; amount = 4'd5;
      tick();
      start = 1'b0;
      tick();
      tick();
      load = 1'b1; load_data = 8'h3C;
      tick();
      load = 1'b0;
      tests_run++;
      if (q !== 8'h3C || busy !== 1'b0 || done !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL abort: q=%h busy=%b done=%b, expected q=3c busy=0 done=0", q, busy, done);
      end
      tick();
      tests_run++;
      if (done !== 1'b0 || q !== 8'h3C) begin
         tests_failed++;
         $display("[TB] FAIL abort after: done=%b q=%h, expected done=0 q=3c", done, q);
      end
      start = 1'b1; op = 3'b001; amount = 4'd5;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tests_run++;
      if ({q, serial_out, busy, done} !== {8'h00, 1'b0, 1'b0, 1'b0}) begin
         tests_failed++;
         $display("[TB] FAIL mid_run_reset: q=%h so=%b busy=%b done=%b, expected all zero",
                  q, serial_out, busy, done);
      end
      load = 1'b1; load_data = 8'h01;
      tick();
      load = 1'b0; start = 1'b1; op = 3'b100; amount = 4'd2; serial_in = 1'b0;
      tick();
      start = 1'b0;
      tick();
      tick();
      tests_run++;
      if (q !== 8'h04 || done !== 1'b1 || busy !== 1'b0) begin
         tests_failed++;
         $display("[TB] FAIL post_reset_op: q=%h done=%b busy=%b, expected q=04 done=1 busy=0",
                  q, done, busy);
      end
      tick();
   endtask

   task automatic test_back_to_back();
      int seen_done;
      en = 1'b1;
      load = 1'b1; load_data = 8'h02;
      tick();
      load = 1'b0; start = 1'b1; op = 3'b001; amount = 4'd1;
      tick();
      op = 3'b010; amount = 4'd2;
      tick();
      seen_done = int'(done);
      tick();
      start = 1'b0;
      tests_run++;
      if (seen_done != 1 || busy !== 1'b1 || q !== m_q[7:0] || busy !== m_busy[0]) begin
         tests_failed++;
         $display("[TB] FAIL back_to_back: done_before=%0d busy=%b q=%h, expected done_before=1 busy=1 q=%h",
                  seen_done, busy, q, m_q[7:0]);
      end
      tick();
      tick();
      tests_run++;
      if (q !== 8'h04 || done !== 1'b1) begin
         tests_failed++;
         $display("[TB] FAIL back_to_back final: q=%h done=%b, expected q=04 done=1", q, done);
      end
      tick();
   endtask

   task automatic test_random();
      int errs;
      errs = 0;
      for (int i = 0; i < 1500; i++) begin
         reset     = ($urandom_range(0, 99) == 0);
         load      = ($urandom_range(0, 15) == 0);
         start     = ($urandom_range(0, 3) == 0);
         en        = ($urandom_range(0, 3) != 0);
         op        = 3'($urandom_range(0, 7));
         amount    = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
         load_data = 8'($urandom);
         serial_in = 1'($urandom);
         tick();
         tests_run++;
         if ({q, serial_out, busy, done} !== {m_q[7:0], m_so[0], m_busy[0], m_done[0]}) begin
            tests_failed++;
            errs++;
            if (errs <= 10)
               $display("[TB] FAIL random cycle %0d: q=%h so=%b busy=%b done=%b, expected q=%h so=%b busy=%b done=%b",
                        i, q, serial_out, busy, done, m_q[7:0], m_so[0], m_busy[0], m_done[0]);
         end
      end
      reset = 1'b0; load = 1'b0; start = 1'b0;
   endtask

   // Test sequence
   initial begin
      test_reset();
      test_shift_ops();
      test_stall();
      test_zero_and_priority();
      test_abort_reset();
      test_back_to_back();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
